// File: rtl/dm_cache_data_refill.sv
// rtl/dm_cache_data_refill.sv - direct-mapped cache data array with registered read, byte-enabled write and line refill engine
// Optional build macro: DM_CACHE_DATA_BYPASS_EN (same-cycle write-to-read bypass on the read port)
module dm_cache_data_refill #(
    parameter int INDEX_W = 10,
    parameter int LINE_W  = 128,
    parameter int BEAT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [INDEX_W-1:0]    rd_index,
    output logic [LINE_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [INDEX_W-1:0]    wr_index,
    input  logic [LINE_W-1:0]     wr_data,
    input  logic [LINE_W/8-1:0]   wr_be,
    output logic                  wr_ready,
    input  logic                  fill_start,
    input  logic [INDEX_W-1:0]    fill_index,
    output logic                  fill_busy,
    input  logic                  beat_valid,
    input  logic [BEAT_W-1:0]     beat_data,
    output logic                  beat_ready,
    output logic                  fill_done
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BYTES = LINE_W / 8;
    localparam int DEPTH = 1 << INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [INDEX_W-1:0] fill_idx;
    logic [LINE_W-1:0]  line_buf;
    logic [LINE_W-1:0]  cpu_line;
    logic               beat_fire;
    logic               last_beat;
    logic               cpu_fire;
    logic               commit_fire;

    // Array contents start at zero; reset deliberately leaves them alone.
    logic [LINE_W-1:0]  mem [DEPTH] = '{default: '0};

    assign beat_ready  = (state == ST_FILL);
    assign fill_busy   = (state != ST_IDLE);
    assign fill_done   = (state == ST_COMMIT);
    // The array has one write port, so the refill commit locks out CPU writes.
    assign wr_ready    = (state != ST_COMMIT);
    assign beat_fire   = beat_valid && beat_ready;
    assign last_beat   = (cnt == CNT_W'(BEATS - 1));
    assign cpu_fire    = wr_en && wr_ready && !rst;
    assign commit_fire = (state == ST_COMMIT) && !rst;

    // Refill state and beat counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Refill next-state: collect BEATS beats, then spend one cycle committing
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (fill_start) begin
                    state_next = ST_FILL;
                    cnt_next   = '0;
                end
            end
            ST_FILL: begin
                if (beat_fire) begin
                    if (last_beat) begin
                        state_next = ST_COMMIT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Latch the refill target and assemble beats, beat 0 in the LSBs
    always_ff @(posedge clk) begin
        if (!rst && state == ST_IDLE && fill_start) begin
            fill_idx <= fill_index;
        end
        if (!rst && beat_fire) begin
            line_buf[int'(cnt) * BEAT_W +: BEAT_W] <= beat_data;
        end
    end

    // Post-write view of the CPU target line: old bytes with enabled bytes replaced
    always_comb begin
        cpu_line = mem[wr_index];
        for (int k = 0; k < BYTES; k++) begin
            if (wr_be[k]) begin
                cpu_line[8*k +: 8] = wr_data[8*k +: 8];
            end
        end
    end

    // Single array write port: refill commit, otherwise an accepted CPU write
    always_ff @(posedge clk) begin
        if (commit_fire) begin
            mem[fill_idx] <= line_buf;
        end else if (cpu_fire) begin
            mem[wr_index] <= cpu_line;
        end
    end

    // Registered read port; rd_data holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
`ifdef DM_CACHE_DATA_BYPASS_EN
                if (commit_fire && rd_index == fill_idx) begin
                    rd_data <= line_buf;
                end else if (cpu_fire && rd_index == wr_index) begin
                    rd_data <= cpu_line;
                end else begin
                    rd_data <= mem[rd_index];
                end
`else
                rd_data <= mem[rd_index];
`endif
            end
        end
    end

endmodule
